// File: rtl/rr_replay_pkg.sv
// rtl/rr_replay_pkg.sv - shared types and handshake constants for replay channel modules
package rr_replay_pkg;

  typedef enum logic {
    RPL_IDLE  = 1'b0,
    RPL_ISSUE = 1'b1
  } rpl_state_t;

  localparam int RPL_DATA_WIDTH    = 32;
  localparam int RPL_BUF_DEPTH     = 4;
  localparam int RPL_END_CNT_WIDTH = 4;

  // Entries that must be buffered (head included) to keep issuing without an idle cycle
  localparam int RPL_BURST_MIN_CNT = 2;

endpackage

// File: rtl/twowayhandshake_replay_fifo.sv
// rtl/twowayhandshake_replay_fifo.sv - synchronous replay buffer holding logged start packets
module twowayhandshake_replay_fifo
  import rr_replay_pkg::*;
#(
  parameter int DATA_WIDTH = RPL_DATA_WIDTH,
  parameter int BUF_DEPTH  = RPL_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(BUF_DEPTH):0]   count,
  output logic [DATA_WIDTH-1:0]        head
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == CW'(BUF_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/twowayhandshake_replayer.sv
// rtl/twowayhandshake_replayer.sv - re-issues logged start packets to the cl and reports end events
module twowayhandshake_replayer
  import rr_replay_pkg::*;
#(
  parameter int DATA_WIDTH    = RPL_DATA_WIDTH,
  parameter int BUF_DEPTH     = RPL_BUF_DEPTH,
  parameter int END_CNT_WIDTH = RPL_END_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         issue_en,
  input  logic                         rpl_valid,
  output logic                         rpl_ready,
  input  logic [DATA_WIDTH-1:0]        rpl_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         rple_valid,
  input  logic                         rple_ready,
  output logic [END_CNT_WIDTH-1:0]     pend_ends,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int PW = END_CNT_WIDTH + 1;
  localparam logic [END_CNT_WIDTH-1:0] END_MAX = '1;

  rpl_state_t               state_q, state_d;
  logic [END_CNT_WIDTH-1:0] pend_q, pend_d;
  logic                     head_rdy_q, head_rdy_d;
  logic                     rdy_en_q, rdy_en_d;
  logic [PW-1:0]            pend_after_fire;

  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [DATA_WIDTH-1:0]    fifo_head;
  logic                     rpl_fire, out_fire, rple_fire;

  twowayhandshake_replay_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rpl_fire),
    .push_data (rpl_data),
    .pop       (out_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign rpl_ready  = rdy_en_q && !fifo_full;
  assign out_valid  = (state_q == RPL_ISSUE);
  assign out_data   = fifo_head;
  assign rple_valid = (pend_q != '0);
  assign pend_ends  = pend_q;
  assign buf_count  = fifo_count;

  assign rpl_fire  = rpl_valid && rpl_ready;
  assign out_fire  = out_valid && out_ready;
  assign rple_fire = rple_valid && rple_ready;

  // A fresh head must sit in the buffer one full cycle before it may be issued,
  // giving the two-cycle write-to-issue latency the logging side expects.
  always_comb begin
    head_rdy_d      = !fifo_empty;
    rdy_en_d        = 1'b1;
    pend_after_fire = {1'b0, pend_q} + PW'(1) - PW'(rple_fire);
    state_d         = state_q;
    unique case (state_q)
      RPL_IDLE: begin
        if (head_rdy_q && !fifo_empty && issue_en && (pend_q < END_MAX)) begin
          state_d = RPL_ISSUE;
        end
      end
      RPL_ISSUE: begin
        if (out_ready) begin
          if ((fifo_count >= CW'(RPL_BURST_MIN_CNT)) && issue_en &&
              (pend_after_fire < {1'b0, END_MAX})) begin
            state_d = RPL_ISSUE;
          end else begin
            state_d = RPL_IDLE;
          end
        end
      end
      default: state_d = RPL_IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    unique case ({out_fire, rple_fire})
      2'b10:   pend_d = pend_q + END_CNT_WIDTH'(1);
      2'b01:   pend_d = pend_q - END_CNT_WIDTH'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RPL_IDLE;
      pend_q     <= '0;
      head_rdy_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      head_rdy_q <= head_rdy_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  property p_out_hold;
    @(posedge clk) disable iff (!rstn)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data));
  endproperty
  a_out_hold: assert property (p_out_hold);

  property p_rple_hold;
    @(posedge clk) disable iff (!rstn)
      (rple_valid && !rple_ready) |=> rple_valid;
  endproperty
  a_rple_hold: assert property (p_rple_hold);

endmodule

// File: tb/tb_twowayhandshake_replayer.sv
// tb/tb_twowayhandshake_replayer.sv - self-checking bench for twowayhandshake_replayer
module tb_twowayhandshake_replayer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        issue_en, rpl_valid, rpl_ready, out_valid, out_ready, rple_valid, rple_ready;
  logic [31:0] rpl_data, out_data;
  logic [3:0]  pend_ends;
  logic [2:0]  buf_count;

  logic        b_issue_en, b_rpl_valid, b_rpl_ready, b_out_valid, b_out_ready;
  logic        b_rple_valid, b_rple_ready;
  logic [31:0] b_rpl_data, b_out_data;
  logic [1:0]  b_pend_ends;
  logic [2:0]  b_buf_count;

  twowayhandshake_replayer #(.DATA_WIDTH(32), .BUF_DEPTH(4), .END_CNT_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .issue_en(issue_en),
    .rpl_valid(rpl_valid), .rpl_ready(rpl_ready), .rpl_data(rpl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rple_valid(rple_valid), .rple_ready(rple_ready),
    .pend_ends(pend_ends), .buf_count(buf_count)
  );

  twowayhandshake_replayer #(.DATA_WIDTH(32), .BUF_DEPTH(4), .END_CNT_WIDTH(2)) dut_e2 (
    .clk(clk), .rstn(rstn), .issue_en(b_issue_en),
    .rpl_valid(b_rpl_valid), .rpl_ready(b_rpl_ready), .rpl_data(b_rpl_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .rple_valid(b_rple_valid), .rple_ready(b_rple_ready),
    .pend_ends(b_pend_ends), .buf_count(b_buf_count)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        ie;
    logic        ordy;
    logic        erdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ev;
    logic [3:0]  e_pend;
    logic [2:0]  e_buf;
    logic        e_rr;
  } vec_t;

  vec_t vecs[22];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        mon_en  = 1'b0;
  logic        mon2_en = 1'b0;
  logic [31:0] fire_data[$];
  int          fire_cyc[$];
  logic [31:0] fire2_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      fire_data.push_back(out_data);
      fire_cyc.push_back(cyc);
    end
    if (mon2_en && b_out_valid && b_out_ready) begin
      fire2_data.push_back(b_out_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic ie,
                              input logic ordy, input logic erdy, input logic e_ov,
                              input logic [31:0] e_od, input logic e_ev,
                              input logic [3:0] e_pend, input logic [2:0] e_buf,
                              input logic e_rr);
    vec_t v;
    v = '{rv, rd, ie, ordy, erdy, e_ov, e_od, e_ev, e_pend, e_buf, e_rr};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    logic seen_ov;

    // single transaction, then end event consumed
    vecs[0]  = mk(1, 32'hA5, 1, 1, 0,  0, 0,     0, 0, 1, 1);
    vecs[1]  = mk(0, 0,      1, 1, 0,  0, 0,     0, 0, 1, 1);
    vecs[2]  = mk(0, 0,      1, 1, 0,  1, 32'hA5, 0, 0, 1, 1);
    vecs[3]  = mk(0, 0,      1, 1, 0,  0, 0,     1, 1, 0, 1);
    vecs[4]  = mk(0, 0,      1, 1, 1,  0, 0,     0, 0, 0, 1);
    // backpressure with issue_en toggling; rple_ready at zero is ignored
    vecs[5]  = mk(1, 32'h11, 1, 0, 1,  0, 0,     0, 0, 1, 1);
    vecs[6]  = mk(1, 32'h22, 1, 0, 1,  0, 0,     0, 0, 2, 1);
    vecs[7]  = mk(0, 0,      1, 0, 1,  1, 32'h11, 0, 0, 2, 1);
    vecs[8]  = mk(0, 0,      0, 0, 1,  1, 32'h11, 0, 0, 2, 1);
    vecs[9]  = mk(0, 0,      1, 0, 1,  1, 32'h11, 0, 0, 2, 1);
    vecs[10] = mk(0, 0,      0, 0, 1,  1, 32'h11, 0, 0, 2, 1);
    vecs[11] = mk(0, 0,      1, 0, 1,  1, 32'h11, 0, 0, 2, 1);
    vecs[12] = mk(0, 0,      0, 0, 1,  1, 32'h11, 0, 0, 2, 1);
    vecs[13] = mk(0, 0,      1, 1, 1,  1, 32'h22, 1, 1, 1, 1);
    vecs[14] = mk(0, 0,      1, 1, 1,  0, 0,     1, 1, 0, 1);
    vecs[15] = mk(0, 0,      1, 0, 0,  0, 0,     1, 1, 0, 1);
    // full buffer with issue blocked
    for (int i = 0; i < 6; i++) begin
      vecs[16+i] = mk(1, 32'h50 + i, 0, 0, 0, 0, 0, 1, 1,
                      (i + 1 < 4) ? 3'(i + 1) : 3'd4, (i + 1 < 4));
    end

    rstn = 1'b1;
    issue_en = 0; rpl_valid = 0; rpl_data = 0; out_ready = 0; rple_ready = 0;
    b_issue_en = 0; b_rpl_valid = 0; b_rpl_data = 0; b_out_ready = 0; b_rple_ready = 0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_rple_valid", {31'd0, rple_valid}, 0);
    chk("reset_rpl_ready", {31'd0, rpl_ready}, 0);
    chk("reset_buf_count", {29'd0, buf_count}, 0);
    chk("reset_pend_ends", {28'd0, pend_ends}, 0);
    rstn = 1'b1;
    tick();
    chk("release_rpl_ready", {31'd0, rpl_ready}, 1);

    for (int r = 0; r < 22; r++) begin
      rpl_valid  = vecs[r].rv;
      rpl_data   = vecs[r].rd;
      issue_en   = vecs[r].ie;
      out_ready  = vecs[r].ordy;
      rple_ready = vecs[r].erdy;
      tick();
      chk($sformatf("vec%0d_out_valid", r), {31'd0, out_valid}, {31'd0, vecs[r].e_ov});
      if (vecs[r].e_ov) chk($sformatf("vec%0d_out_data", r), out_data, vecs[r].e_od);
      chk($sformatf("vec%0d_rple_valid", r), {31'd0, rple_valid}, {31'd0, vecs[r].e_ev});
      chk($sformatf("vec%0d_pend_ends", r), {28'd0, pend_ends}, {28'd0, vecs[r].e_pend});
      chk($sformatf("vec%0d_buf_count", r), {29'd0, buf_count}, {29'd0, vecs[r].e_buf});
      chk($sformatf("vec%0d_rpl_ready", r), {31'd0, rpl_ready}, {31'd0, vecs[r].e_rr});
    end

    // reset while a transaction is being offered
    rpl_valid = 0; issue_en = 1; out_ready = 0; rple_ready = 0;
    tick();
    chk("pre_reset_out_valid", {31'd0, out_valid}, 1);
    chk("pre_reset_out_data", out_data, 32'h50);
    #2 rstn = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 0);
    chk("midreset_buf_count", {29'd0, buf_count}, 0);
    chk("midreset_pend_ends", {28'd0, pend_ends}, 0);
    chk("midreset_rple_valid", {31'd0, rple_valid}, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_reset_rpl_ready", {31'd0, rpl_ready}, 1);

    // streaming: eight packets must leave on consecutive cycles in order
    issue_en = 1; out_ready = 1; rple_ready = 1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rpl_valid = 1; rpl_data = 32'(i);
      tick();
    end
    rpl_valid = 0;
    repeat (12) tick();
    mon_en = 1'b0;
    chk("stream_fire_count", 32'(fire_data.size()), 8);
    for (int i = 0; i < fire_data.size() && i < 8; i++) begin
      chk($sformatf("stream_data%0d", i), fire_data[i], 32'(i));
      chk($sformatf("stream_cycle%0d", i), 32'(fire_cyc[i] - fire_cyc[0]), 32'(i));
    end
    chk("stream_pend_ends", {28'd0, pend_ends}, 0);
    chk("stream_buf_count", {29'd0, buf_count}, 0);

    // end-counter stall on a 2-bit counter: three issue, then hold until ends drain
    b_issue_en = 1; b_out_ready = 1; b_rple_ready = 0;
    mon2_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_rpl_valid = 1; b_rpl_data = 32'h100 + i;
      tick();
    end
    b_rpl_valid = 0;
    seen_ov = 1'b0;
    repeat (6) begin
      tick();
      seen_ov = seen_ov | b_out_valid;
    end
    chk("stall_fire_count", 32'(fire2_data.size()), 3);
    chk("stall_out_valid", {31'd0, seen_ov}, 0);
    chk("stall_pend_ends", {30'd0, b_pend_ends}, 3);
    chk("stall_buf_count", {29'd0, b_buf_count}, 3);
    chk("stall_rple_valid", {31'd0, b_rple_valid}, 1);
    b_rple_ready = 1;
    for (int k = 0; k < 40 && fire2_data.size() < 6; k++) tick();
    repeat (4) tick();
    mon2_en = 1'b0;
    chk("drain_fire_count", 32'(fire2_data.size()), 6);
    for (int i = 0; i < fire2_data.size() && i < 6; i++) begin
      chk($sformatf("drain_data%0d", i), fire2_data[i], 32'h100 + i);
    end
    chk("drain_pend_ends", {30'd0, b_pend_ends}, 0);
    chk("drain_buf_count", {29'd0, b_buf_count}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
